// File: rtl/writeback_stage.sv
// writeback_stage: MEM->WB pipeline register and result formatter.
// Formats load data (byte/half lane select with sign or zero extension),
// selects the final result from ALU, load data or PC+4, and registers it
// together with the register-file write controls. The register file commits
// on the following negedge, so decode sees the value in the same cycle.
// Also keeps a free-running count of instructions captured into WB.
// Byte-lane handling assumes a 32-bit datapath.
module writeback_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     valid_m,
  input  logic                     reg_write_m,
  input  logic [1:0]               result_src_m,
  input  logic [2:0]               funct3_m,
  input  logic [ADDRESS_WIDTH-1:0] rd_m,
  input  logic [DATA_WIDTH-1:0]    alu_result_m,
  input  logic [DATA_WIDTH-1:0]    read_data_m,
  input  logic [DATA_WIDTH-1:0]    pc_plus4_m,
  output logic                     valid_w,
  output logic                     reg_write_w,
  output logic [ADDRESS_WIDTH-1:0] rd_w,
  output logic [DATA_WIDTH-1:0]    result_w,
  output logic [31:0]              retired
);

  // Result select encodings; 2'b11 falls through to the ALU result.
  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  // RV32I load funct3 encodings; reserved codes load the full word.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic [DATA_WIDTH-1:0]    w_load;
  logic [DATA_WIDTH-1:0]    w_result;
  logic                     w_write_en;

  logic                     r_valid;
  logic                     r_reg_write;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0]    r_result;
  logic [31:0]              r_retired;

  // Pick the addressed byte and half out of the aligned memory word.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_byte = read_data_m[7:0];
    w_half = read_data_m[15:0];
    case (alu_result_m[1:0])
      2'd0:    w_byte = read_data_m[7:0];
      2'd1:    w_byte = read_data_m[15:8];
      2'd2:    w_byte = read_data_m[23:16];
      default: w_byte = read_data_m[31:24];
    endcase
    // Halfword lane comes from the upper address bit only; bit 0 is ignored,
    // so misaligned halves silently read the enclosing aligned half.
    if (alu_result_m[1]) begin
      w_half = read_data_m[31:16];
    end
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    w_load = read_data_m;
    case (funct3_m)
      F3_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  w_load = {24'h000000, w_byte};
      F3_LH:   w_load = {{16{w_half[15]}}, w_half};
      F3_LHU:  w_load = {16'h0000, w_half};
      default: w_load = read_data_m;
    endcase
  end

  // Final result mux; only the load path is formatted.
  always_comb begin
    w_result = alu_result_m;
    case (result_src_m)
      SRC_ALU:  w_result = alu_result_m;
      SRC_LOAD: w_result = w_load;
      SRC_PC4:  w_result = pc_plus4_m;
      default:  w_result = alu_result_m;
    endcase
  end

  // Writes to x0 and writes from bubbles are never issued.
  assign w_write_en = valid_m & reg_write_m & (rd_m != '0);

  // Pipeline register: reset > flush (bubble) > stall (hold) > capture.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_result    <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_result    <= '0;
    end else if (!stall) begin
      r_valid     <= valid_m;
      r_reg_write <= w_write_en;
      r_rd        <= rd_m;
      r_result    <= w_result;
    end
  end

  // Retired count: bumps on every capture of a real instruction, wraps freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= 32'h0;
    end else if (!flush && !stall) begin
      r_retired <= r_retired + {31'h0, valid_m};
    end
  end

  assign valid_w     = r_valid;
  assign reg_write_w = r_reg_write;
  assign rd_w        = r_rd;
  assign result_w    = r_result;
  assign retired     = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: table vectors, hand sequences for stall/flush/wrap,
// and a randomized run against a behavioural model of the WB stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_m, reg_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
  logic        valid_w, reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w, retired;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic        m_valid, m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_result, m_retired;

  typedef struct {
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        exp_we;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[13];

  writeback_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_m(valid_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .funct3_m(funct3_m), .rd_m(rd_m),
    .alu_result_m(alu_result_m), .read_data_m(read_data_m),
    .pc_plus4_m(pc_plus4_m),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result as the instruction set defines it: shift the addressed lane down,
  // mask it, then extend by arithmetic when the load is signed.
  function automatic logic [31:0] ref_result(input logic [1:0] src,
      input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
      input logic [31:0] pc);
    logic [31:0] v;
    int unsigned off;
    if (src == 2'b10) return pc;
    if (src != 2'b01) return alu;
    off = alu[1:0];
    case (f3)
      3'b000, 3'b100: begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'h80) v = v - 32'h100;
      end
      3'b001, 3'b101: begin
        v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_valid = 0; m_we = 0; m_rd = 0; m_result = 0; m_retired = 0;
    end else if (flush) begin
      m_valid = 0; m_we = 0; m_rd = 0; m_result = 0;
    end else if (!stall) begin
      m_valid   = valid_m;
      m_we      = valid_m && reg_write_m && rd_m != 0;
      m_rd      = rd_m;
      m_result  = ref_result(result_src_m, funct3_m, alu_result_m,
                             read_data_m, pc_plus4_m);
      m_retired = m_retired + (valid_m ? 32'd1 : 32'd0);
    end
  endtask

  // One clock: model follows the posedge, outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_data();
    valid_m      = 1'($urandom);
    reg_write_m  = 1'($urandom);
    result_src_m = 2'($urandom);
    funct3_m     = 3'($urandom);
    rd_m         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    alu_result_m = $urandom;
    read_data_m  = $urandom;
    pc_plus4_m   = $urandom;
  endtask

  task automatic drive_op(input logic v, input logic we, input logic [1:0] src,
      input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
      input logic [31:0] rdata, input logic [31:0] pc);
    valid_m = v; reg_write_m = we; result_src_m = src; funct3_m = f3;
    rd_m = rd; alu_result_m = alu; read_data_m = rdata; pc_plus4_m = pc;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic we,
      input logic [4:0] rd, input logic [31:0] res, input logic [31:0] ret);
    check({tag, ".valid_w"},     32'(valid_w),     32'(v));
    check({tag, ".reg_write_w"}, 32'(reg_write_w), 32'(we));
    check({tag, ".rd_w"},        32'(rd_w),        32'(rd));
    check({tag, ".result_w"},    result_w,         res);
    check({tag, ".retired"},     retired,          ret);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 3'b000, 5'd5,  1'b1, 32'h12345678, 32'hDEADBEEF, 32'h4, 1'b1, 32'h12345678};
    vecs[1]  = '{2'b01, 3'b000, 5'd6,  1'b1, 32'h00001003, 32'h80FF7F01, 32'h0, 1'b1, 32'hFFFFFF80};
    vecs[2]  = '{2'b01, 3'b100, 5'd7,  1'b1, 32'h00001001, 32'h80FF7F01, 32'h0, 1'b1, 32'h0000007F};
    vecs[3]  = '{2'b01, 3'b001, 5'd8,  1'b1, 32'h00001002, 32'h80FF7F01, 32'h0, 1'b1, 32'hFFFF80FF};
    vecs[4]  = '{2'b01, 3'b101, 5'd9,  1'b1, 32'h00001000, 32'h80FF7F01, 32'h0, 1'b1, 32'h00007F01};
    vecs[5]  = '{2'b01, 3'b010, 5'd10, 1'b1, 32'h00001000, 32'h80FF7F01, 32'h0, 1'b1, 32'h80FF7F01};
    vecs[6]  = '{2'b01, 3'b001, 5'd11, 1'b1, 32'h00001003, 32'h80FF7F01, 32'h0, 1'b1, 32'hFFFF80FF};
    vecs[7]  = '{2'b01, 3'b110, 5'd12, 1'b1, 32'h00001002, 32'h80FF7F01, 32'h0, 1'b1, 32'h80FF7F01};
    vecs[8]  = '{2'b10, 3'b000, 5'd1,  1'b1, 32'h00000055, 32'h80FF7F01, 32'h104, 1'b1, 32'h00000104};
    vecs[9]  = '{2'b00, 3'b000, 5'd0,  1'b1, 32'h0000CAFE, 32'h80FF7F01, 32'h0, 1'b0, 32'h0000CAFE};
    vecs[10] = '{2'b11, 3'b000, 5'd13, 1'b0, 32'h0BADF00D, 32'h80FF7F01, 32'h8, 1'b0, 32'h0BADF00D};
    vecs[11] = '{2'b01, 3'b000, 5'd14, 1'b1, 32'h00001000, 32'h80FF7F01, 32'h0, 1'b1, 32'h00000001};
    vecs[12] = '{2'b01, 3'b100, 5'd15, 1'b1, 32'h00001003, 32'h80FF7F01, 32'h0, 1'b1, 32'h00000080};

    rst = 1; stall = 0; flush = 0;
    drive_op(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset with random inputs, including random flush/stall.
    for (int i = 0; i < 2; i++) begin
      rand_data();
      stall = 1'($urandom); flush = 1'($urandom);
      tick();
      check_outs($sformatf("reset%0d", i), 0, 0, 0, 0, 0);
    end
    rst = 0; stall = 0; flush = 0;

    // Table vectors: one capture each, retired counts up from 0.
    for (int i = 0; i < 13; i++) begin
      drive_op(1, vecs[i].we, vecs[i].src, vecs[i].f3, vecs[i].rd,
               vecs[i].alu, vecs[i].rdata, vecs[i].pc);
      tick();
      check_outs($sformatf("vec%0d", i), 1, vecs[i].exp_we, vecs[i].rd,
                 vecs[i].exp_res, 32'(i + 1));
    end

    // Capture A, stall three cycles, then flush together with stall.
    drive_op(1, 1, 2'b00, 3'b000, 5'd7, 32'hA5A50001, 32'h0, 32'h0);
    tick();
    check_outs("capA", 1, 1, 7, 32'hA5A50001, 32'd14);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      tick();
      check_outs($sformatf("stall%0d", i), 1, 1, 7, 32'hA5A50001, 32'd14);
    end
    rand_data();
    valid_m = 1;
    flush = 1;
    tick();
    check_outs("flush", 0, 0, 0, 0, 32'd14);
    stall = 0; flush = 0;

    // Bubble asking for a write: no write, rd/result still captured.
    drive_op(0, 1, 2'b00, 3'b000, 5'd3, 32'h00C0FFEE, 32'h0, 32'h0);
    tick();
    check_outs("bubble_we", 0, 0, 3, 32'h00C0FFEE, 32'd14);

    // Counter wrap: preload all-ones while stalled, then one capture.
    stall = 1;
    force dut.r_retired = 32'hFFFFFFFF;
    tick();
    release dut.r_retired;
    #1;
    check("wrap.preload", retired, 32'hFFFFFFFF);
    @(negedge clk);
    stall = 0;
    drive_op(1, 1, 2'b10, 3'b000, 5'd1, 32'h0, 32'h0, 32'h00000104);
    tick();
    check_outs("wrap", 1, 1, 1, 32'h00000104, 32'h0);

    // Randomized run against the model, starting from a reset.
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      tick();
      if (valid_w !== m_valid || reg_write_w !== m_we || rd_w !== m_rd ||
          result_w !== m_result || retired !== m_retired) begin
        check_outs($sformatf("rand%0d", i), m_valid, m_we, m_rd, m_result,
                   m_retired);
      end else begin
        total++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
